if_neuron_sched: RTL and testbench

- Sequencer for the shared IF neuron datapath. It time-multiplexes one neuron update unit over N_POST post-synaptic neurons held in state SRAM.
- Accepts pre-synaptic AER events, end-of-time-step requests and end-of-sample (reference) requests.
- For each accepted command it sweeps every post neuron: read SRAM, strobe the matching neuron event, write the result back.
- Emits output spikes as AER events, tracks current_time_step, and sits between the input AER FIFO and the neuron core / state SRAM.

---
 rtl/snn_ctrl_pkg.sv | 12 +
 rtl/if_neuron_sched_if.sv | 45 ++++
 rtl/if_sweep_cnt.sv | 40 ++++
 rtl/if_neuron_sched.sv | 193 +++++++++++++++++++
 tb/tb_if_neuron_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared types and default sizing for the SNN control sequencers.
package snn_ctrl_pkg;

  localparam int unsigned N_POST_DEF    = 256;
  localparam int unsigned TIME_STEP_DEF = 8;
  localparam int unsigned AER_WIDTH_DEF = 12;

  typedef enum logic [1:0] {ACC, STEP, REF} sweep_e;

  typedef enum logic [2:0] {IDLE, RD, EXE, SPK, DONE} state_e;

endpackage

// File: rtl/if_neuron_sched_if.sv
// Signal bundle between the IF neuron scheduler and its surroundings
// (AER FIFOs, command requesters, neuron core and state/weight SRAM).
interface if_neuron_sched_if #(
  parameter int unsigned N_POST    = snn_ctrl_pkg::N_POST_DEF,
  parameter int unsigned AER_WIDTH = snn_ctrl_pkg::AER_WIDTH_DEF,
  parameter int unsigned TIME_STEP = snn_ctrl_pkg::TIME_STEP_DEF
);
  localparam int unsigned POST_ADDR_W = $clog2(N_POST);
  localparam int unsigned TS_W        = $clog2(TIME_STEP);

  logic                             aer_in_valid;
  logic [AER_WIDTH-1:0]             aer_in_addr;
  logic                             aer_in_ready;
  logic                             step_req;
  logic                             ref_req;
  logic                             cmd_ack;
  logic                             sram_re;
  logic                             sram_we;
  logic [POST_ADDR_W-1:0]           sram_addr;
  logic [AER_WIDTH+POST_ADDR_W-1:0] syn_addr;
  logic                             neuron_event;
  logic                             time_step_event;
  logic                             time_ref_event;
  logic [TS_W-1:0]                  current_time_step;
  logic                             spike_in;
  logic                             aer_out_valid;
  logic [AER_WIDTH-1:0]             aer_out_addr;
  logic                             aer_out_ready;
  logic                             busy;

  modport master (
    output aer_in_valid, aer_in_addr, step_req, ref_req, spike_in, aer_out_ready,
    input  aer_in_ready, cmd_ack, sram_re, sram_we, sram_addr, syn_addr,
           neuron_event, time_step_event, time_ref_event, current_time_step,
           aer_out_valid, aer_out_addr, busy
  );

  modport slave (
    input  aer_in_valid, aer_in_addr, step_req, ref_req, spike_in, aer_out_ready,
    output aer_in_ready, cmd_ack, sram_re, sram_we, sram_addr, syn_addr,
           neuron_event, time_step_event, time_ref_event, current_time_step,
           aer_out_valid, aer_out_addr, busy
  );

endinterface

// File: rtl/if_sweep_cnt.sv
// Post-neuron sweep index counter plus the wrapping time-step counter.
module if_sweep_cnt #(
  parameter int unsigned N_POST    = 256,
  parameter int unsigned TIME_STEP = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         clr,
  input  logic                         inc,
  input  logic                         ts_inc,
  input  logic                         ts_clr,
  output logic [$clog2(N_POST)-1:0]    idx,
  output logic [$clog2(N_POST)-1:0]    idx_nxt,
  output logic                         last,
  output logic [$clog2(TIME_STEP)-1:0] ts
);
  localparam int unsigned POST_ADDR_W = $clog2(N_POST);
  localparam int unsigned TS_W        = $clog2(TIME_STEP);

  assign idx_nxt = idx + POST_ADDR_W'(1);
  assign last    = (idx == POST_ADDR_W'(N_POST - 1));

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx_nxt;
    end
  end

  // Time step wraps explicitly so non-power-of-two TIME_STEP also works.
  always_ff @(posedge CLK) begin
    if (RST || ts_clr) begin
      ts <= '0;
    end else if (ts_inc) begin
      ts <= (ts == TS_W'(TIME_STEP - 1)) ? '0 : ts + TS_W'(1);
    end
  end

endmodule

// File: rtl/if_neuron_sched.sv
// Sequencer that time-multiplexes one IF neuron update unit over N_POST
// neurons in state SRAM for accumulate, time-step and reference sweeps.
module if_neuron_sched
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned N_POST    = N_POST_DEF,
  parameter int unsigned AER_WIDTH = AER_WIDTH_DEF,
  parameter int unsigned TIME_STEP = TIME_STEP_DEF
) (
  input logic              CLK,
  input logic              RST,
  if_neuron_sched_if.slave bus
);
  localparam int unsigned POST_ADDR_W = $clog2(N_POST);
  localparam int unsigned TS_W        = $clog2(TIME_STEP);

  state_e                           state;
  sweep_e                           sweep;
  logic [AER_WIDTH-1:0]             pre;
  logic                             idle_en;
  logic                             busy;
  logic                             sram_re;
  logic                             sram_we;
  logic [POST_ADDR_W-1:0]           sram_addr;
  logic [AER_WIDTH+POST_ADDR_W-1:0] syn_addr;
  logic                             neuron_event;
  logic                             time_step_event;
  logic                             time_ref_event;
  logic                             cmd_ack;
  logic                             aer_out_valid;
  logic [AER_WIDTH-1:0]             aer_out_addr;

  logic [POST_ADDR_W-1:0]           idx;
  logic [POST_ADDR_W-1:0]           idx_nxt;
  logic                             last;
  logic [TS_W-1:0]                  ts;
  logic                             adv;
  logic                             cnt_clr;
  logic                             cnt_inc;
  logic                             ts_inc;
  logic                             ts_clr;

  // Move past the current neuron: after EXE (no spike) or a completed spike handshake.
  always_comb begin
    adv     = ((state == EXE) && !((sweep == STEP) && bus.spike_in)) ||
              ((state == SPK) && bus.aer_out_ready);
    cnt_clr = (state == IDLE) || (state == DONE);
    cnt_inc = adv && !last;
    ts_inc  = adv && last && (sweep == STEP);
    ts_clr  = adv && last && (sweep == REF);
  end

  if_sweep_cnt #(
    .N_POST   (N_POST),
    .TIME_STEP(TIME_STEP)
  ) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .ts_inc (ts_inc),
    .ts_clr (ts_clr),
    .idx    (idx),
    .idx_nxt(idx_nxt),
    .last   (last),
    .ts     (ts)
  );

  // Events are refused whenever a step/ref request is pending.
  assign bus.aer_in_ready = idle_en && !bus.step_req && !bus.ref_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      sweep           <= ACC;
      pre             <= '0;
      idle_en         <= 1'b0;
      busy            <= 1'b0;
      sram_re         <= 1'b0;
      sram_we         <= 1'b0;
      sram_addr       <= '0;
      syn_addr        <= '0;
      neuron_event    <= 1'b0;
      time_step_event <= 1'b0;
      time_ref_event  <= 1'b0;
      cmd_ack         <= 1'b0;
      aer_out_valid   <= 1'b0;
      aer_out_addr    <= '0;
    end else begin
      sram_re         <= 1'b0;
      sram_we         <= 1'b0;
      neuron_event    <= 1'b0;
      time_step_event <= 1'b0;
      time_ref_event  <= 1'b0;
      cmd_ack         <= 1'b0;
      unique case (state)
        IDLE: begin
          idle_en <= 1'b1;
          if (bus.ref_req) begin
            state          <= EXE;
            sweep          <= REF;
            idle_en        <= 1'b0;
            busy           <= 1'b1;
            sram_we        <= 1'b1;
            sram_addr      <= '0;
            time_ref_event <= 1'b1;
          end else if (bus.step_req) begin
            state     <= RD;
            sweep     <= STEP;
            idle_en   <= 1'b0;
            busy      <= 1'b1;
            sram_re   <= 1'b1;
            sram_addr <= '0;
            syn_addr  <= {pre, {POST_ADDR_W{1'b0}}};
          end else if (bus.aer_in_valid && bus.aer_in_ready) begin
            state     <= RD;
            sweep     <= ACC;
            pre       <= bus.aer_in_addr;
            idle_en   <= 1'b0;
            busy      <= 1'b1;
            sram_re   <= 1'b1;
            sram_addr <= '0;
            syn_addr  <= {bus.aer_in_addr, {POST_ADDR_W{1'b0}}};
          end
        end
        RD: begin
          state           <= EXE;
          sram_we         <= 1'b1;
          sram_addr       <= idx;
          neuron_event    <= (sweep == ACC);
          time_step_event <= (sweep == STEP);
          time_ref_event  <= (sweep == REF);
        end
        EXE: begin
          if ((sweep == STEP) && bus.spike_in) begin
            state         <= SPK;
            aer_out_valid <= 1'b1;
            aer_out_addr  <= AER_WIDTH'(idx);
          end
        end
        SPK: begin
          if (bus.aer_out_ready) begin
            aer_out_valid <= 1'b0;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          idle_en <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Next neuron, or close the sweep; accumulate sweeps end without DONE/ack.
      if (adv) begin
        if (last) begin
          if (sweep == ACC) begin
            state   <= IDLE;
            busy    <= 1'b0;
            idle_en <= 1'b1;
          end else begin
            state   <= DONE;
            cmd_ack <= 1'b1;
          end
        end else if (sweep == REF) begin
          state          <= EXE;
          sram_we        <= 1'b1;
          sram_addr      <= idx_nxt;
          time_ref_event <= 1'b1;
        end else begin
          state     <= RD;
          sram_re   <= 1'b1;
          sram_addr <= idx_nxt;
          syn_addr  <= {pre, idx_nxt};
        end
      end
    end
  end

  assign bus.busy              = busy;
  assign bus.sram_re           = sram_re;
  assign bus.sram_we           = sram_we;
  assign bus.sram_addr         = sram_addr;
  assign bus.syn_addr          = syn_addr;
  assign bus.neuron_event      = neuron_event;
  assign bus.time_step_event   = time_step_event;
  assign bus.time_ref_event    = time_ref_event;
  assign bus.cmd_ack           = cmd_ack;
  assign bus.current_time_step = ts;
  assign bus.aer_out_valid     = aer_out_valid;
  assign bus.aer_out_addr      = aer_out_addr;

endmodule

// File: tb/tb_if_neuron_sched.sv
// Directed bench for if_neuron_sched with N_POST=4, AER_WIDTH=12, TIME_STEP=8.
module tb_if_neuron_sched;

  logic CLK;
  logic RST;
  int   n_chk;
  int   n_pass;

  if_neuron_sched_if #(.N_POST(4), .AER_WIDTH(12), .TIME_STEP(8)) bus ();

  if_neuron_sched #(.N_POST(4), .AER_WIDTH(12), .TIME_STEP(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic run_step();
    bit got;
    got = 1'b0;
    bus.step_req = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      cyc();
      if (bus.cmd_ack) begin
        got = 1'b1;
        bus.step_req = 1'b0;
      end
    end
    chk("step_ack_seen", 32'(got), 32'd1);
    cyc();
  endtask

  int n_ref, n_stp, n_acc, acks, rdy_bad, order_bad, n_bad;
  logic [31:0] syn0;
  bit acc_go;

  initial begin
    n_chk = 0;
    n_pass = 0;
    RST = 1'b1;
    bus.aer_in_valid = 1'b0;
    bus.aer_in_addr = '0;
    bus.step_req = 1'b0;
    bus.ref_req = 1'b0;
    bus.spike_in = 1'b0;
    bus.aer_out_ready = 1'b1;

    // Reset held for 3 cycles
    repeat (3) cyc();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.aer_in_ready), 32'd0);
    chk("rst_we", 32'(bus.sram_we), 32'd0);
    chk("rst_ack", 32'(bus.cmd_ack), 32'd0);
    chk("rst_ts", 32'(bus.current_time_step), 32'd0);
    chk("rst_outv", 32'(bus.aer_out_valid), 32'd0);
    RST = 1'b0;
    cyc();
    chk("rel_busy", 32'(bus.busy), 32'd0);
    chk("rel_ready", 32'(bus.aer_in_ready), 32'd1);
    chk("rel_re", 32'(bus.sram_re), 32'd0);
    chk("rel_strobes", 32'({bus.neuron_event, bus.time_step_event, bus.time_ref_event}), 32'd0);

    // Single AER event, addr 5
    bus.aer_in_valid = 1'b1;
    bus.aer_in_addr = 12'd5;
    #1;
    chk("acc_ready", 32'(bus.aer_in_ready), 32'd1);
    cyc();
    bus.aer_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("acc_rd_re", 32'(bus.sram_re), 32'd1);
      chk("acc_rd_addr", 32'(bus.sram_addr), 32'(i));
      chk("acc_syn", 32'(bus.syn_addr), 32'(20 + i));
      chk("acc_rd_busy", 32'(bus.busy), 32'd1);
      cyc();
      chk("acc_nev", 32'(bus.neuron_event), 32'd1);
      chk("acc_we", 32'(bus.sram_we), 32'd1);
      chk("acc_exe_addr", 32'(bus.sram_addr), 32'(i));
      chk("acc_other_strobes", 32'({bus.time_step_event, bus.time_ref_event}), 32'd0);
      chk("acc_exe_busy", 32'(bus.busy), 32'd1);
      cyc();
    end
    chk("acc_end_busy", 32'(bus.busy), 32'd0);
    chk("acc_no_ack", 32'(bus.cmd_ack), 32'd0);
    chk("acc_end_ready", 32'(bus.aer_in_ready), 32'd1);

    // Step sweep, spike at idx 2 with downstream stalled 3 cycles
    bus.step_req = 1'b1;
    bus.aer_out_ready = 1'b0;
    #1;
    chk("step_ready_low", 32'(bus.aer_in_ready), 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("step_rd_addr", 32'(bus.sram_addr), 32'(i));
      chk("step_rd_re", 32'(bus.sram_re), 32'd1);
      cyc();
      chk("step_tse", 32'(bus.time_step_event), 32'd1);
      chk("step_exe_addr", 32'(bus.sram_addr), 32'(i));
      chk("step_nev", 32'(bus.neuron_event), 32'd0);
      if (i == 2) bus.spike_in = 1'b1;
      cyc();
    end
    bus.spike_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("spk_valid", 32'(bus.aer_out_valid), 32'd1);
      chk("spk_addr", 32'(bus.aer_out_addr), 32'd2);
      chk("spk_no_sram", 32'({bus.sram_re, bus.sram_we}), 32'd0);
      chk("spk_no_tse", 32'(bus.time_step_event), 32'd0);
      if (s == 2) bus.aer_out_ready = 1'b1;
      cyc();
    end
    chk("spk_released", 32'(bus.aer_out_valid), 32'd0);
    chk("step_rd3_addr", 32'(bus.sram_addr), 32'd3);
    chk("step_rd3_re", 32'(bus.sram_re), 32'd1);
    cyc();
    chk("step_exe3_tse", 32'(bus.time_step_event), 32'd1);
    cyc();
    chk("step_ack", 32'(bus.cmd_ack), 32'd1);
    chk("step_ts1", 32'(bus.current_time_step), 32'd1);
    bus.step_req = 1'b0;
    cyc();
    chk("step_ack_once", 32'(bus.cmd_ack), 32'd0);
    chk("step_idle", 32'(bus.busy), 32'd0);
    cyc();
    chk("step_no_rerun", 32'(bus.busy), 32'd0);

    // Time step wrap
    repeat (6) run_step();
    chk("ts_seven", 32'(bus.current_time_step), 32'd7);
    run_step();
    chk("ts_wrap", 32'(bus.current_time_step), 32'd0);
    run_step();
    chk("ts_one", 32'(bus.current_time_step), 32'd1);

    // Reference sweep: 4 consecutive clear strobes, no reads
    bus.ref_req = 1'b1;
    #1;
    chk("ref_ready_low", 32'(bus.aer_in_ready), 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("ref_trev", 32'(bus.time_ref_event), 32'd1);
      chk("ref_we", 32'(bus.sram_we), 32'd1);
      chk("ref_re", 32'(bus.sram_re), 32'd0);
      chk("ref_addr", 32'(bus.sram_addr), 32'(i));
      cyc();
    end
    chk("ref_ack", 32'(bus.cmd_ack), 32'd1);
    chk("ref_ts_clear", 32'(bus.current_time_step), 32'd0);
    chk("ref_done_trev", 32'(bus.time_ref_event), 32'd0);
    bus.ref_req = 1'b0;
    cyc();
    chk("ref_idle", 32'(bus.busy), 32'd0);

    // Simultaneous event, step and ref: REF, then STEP, then ACC
    n_ref = 0; n_stp = 0; n_acc = 0; acks = 0; rdy_bad = 0; order_bad = 0;
    syn0 = 32'hFFFF_FFFF;
    bus.aer_in_valid = 1'b1;
    bus.aer_in_addr = 12'd9;
    bus.step_req = 1'b1;
    bus.ref_req = 1'b1;
    #1;
    for (int c = 0; c < 80 && n_acc < 4; c++) begin
      acc_go = bus.aer_in_valid && bus.aer_in_ready;
      if (acks < 2 && bus.aer_in_ready) rdy_bad++;
      cyc();
      if (acc_go) begin
        bus.aer_in_valid = 1'b0;
        syn0 = 32'(bus.syn_addr);
      end
      if (bus.time_ref_event) n_ref++;
      if (bus.time_step_event) begin
        n_stp++;
        if (n_ref != 4) order_bad++;
      end
      if (bus.neuron_event) begin
        n_acc++;
        if (n_stp != 4) order_bad++;
      end
      if (bus.cmd_ack) begin
        acks++;
        if (acks == 1) bus.ref_req = 1'b0;
        else bus.step_req = 1'b0;
      end
    end
    chk("prio_ref_pulses", n_ref, 4);
    chk("prio_step_pulses", n_stp, 4);
    chk("prio_acc_pulses", n_acc, 4);
    chk("prio_order", order_bad, 0);
    chk("prio_ready_low", rdy_bad, 0);
    chk("prio_acks", acks, 2);
    chk("prio_syn0", syn0, 32'd36);
    cyc();
    chk("prio_idle", 32'(bus.busy), 32'd0);
    chk("prio_no_acc_ack", 32'(bus.cmd_ack), 32'd0);

    // Reset in the middle of an accumulate sweep
    bus.aer_in_valid = 1'b1;
    bus.aer_in_addr = 12'd3;
    #1;
    cyc();
    bus.aer_in_valid = 1'b0;
    cyc();
    cyc();
    chk("mid_rd1_addr", 32'(bus.sram_addr), 32'd1);
    chk("mid_rd1_re", 32'(bus.sram_re), 32'd1);
    RST = 1'b1;
    cyc();
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_we", 32'(bus.sram_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.sram_addr), 32'd0);
    chk("mid_rst_nev", 32'(bus.neuron_event), 32'd0);
    RST = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (bus.neuron_event || bus.time_step_event || bus.time_ref_event ||
          bus.sram_we || bus.sram_re || bus.busy) n_bad++;
    end
    chk("mid_rst_quiet", n_bad, 0);
    chk("mid_rst_ready", 32'(bus.aer_in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
